trng_req_arbiter: RTL

//  Shares the single TRNG instance between N_REQ requesters (sandpile grain-drop X/Y, tie-break, colour, ...).

---
 rtl/trng_req_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/trng_req_arbiter.sv
// Round-robin broker for one shared TRNG: warm-up hold-off, resolution mux, settle wait, one draw per grant.
// Grant-to-rsp_valid is SETTLE+1 cycles; a pending response stalls all further grants until rsp_ready.
module trng_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 32,
  parameter int SETTLE = 2,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [9*N_REQ-1:0]   req_res,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [9:0]           rsp_data,
  output logic [8:0]           trng_resolution,
  input  logic [9:0]           trng_random,
  output logic                 busy,
  output logic                 range_err
);

  localparam int CMAX = (WARMUP > SETTLE) ? WARMUP : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_WARM, S_IDLE, S_GRANT, S_SETTLE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [9:0]      data_q, data_d;
  logic [8:0]      res_q, res_d;
  logic            err_q, err_d;

  logic            win_vld;
  logic [IDW-1:0]  win_idx;
  int unsigned     cand;

  // Winner is re-evaluated in GRANT so a request withdrawn after IDLE is never acknowledged.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_q) + i) % N_REQ;
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    id_d      = id_q;
    data_d    = data_q;
    res_d     = res_q;
    err_d     = err_q;
    req_ready = '0;
    case (state_q)
      S_WARM: begin
        res_d = 9'd1;
        if (cnt_q == CW'(WARMUP - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (|req_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (win_vld) begin
          req_ready[win_idx] = 1'b1;
          id_d    = win_idx;
          res_d   = req_res[9*int'(win_idx) +: 9];
          rr_d    = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
          if (res_q == 9'd0) begin
            data_d = 10'd0;
          end else begin
            data_d = trng_random;
            if (trng_random >= {1'b0, res_q}) err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WARM;
      cnt_q   <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      data_q  <= '0;
      res_q   <= 9'd1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid       = (state_q == S_RESP);
  assign rsp_id          = id_q;
  assign rsp_data        = data_q;
  assign trng_resolution = res_q;
  assign busy            = (state_q != S_IDLE);
  assign range_err       = err_q;

endmodule
